vpu_wb_merge_buffer: RTL and testbench
======================================

// Module: vpu_wb_merge_buffer
// PURPOSE
//  Receive end of the VPU lane writeback stream (result valid/addr/bweb/data).
//  Buffers byte-enabled partial vector-register writes in a small FIFO and
//  drains them to the VRF write port under ready/valid backpressure.
//  Asserts stall_o back toward the VPU sequencer before overflow.
//  Exports a pending-write bitmap for the hazard scoreboard.
// PARAMETERS
//  VLEN   64  vector register width in bits; byte lanes = VLEN/8
//  DEPTH  4   FIFO entries (power of two, >=2)
// PORTS
//  clk_i           in   1        clock
//  rst_i           in   1        async reset, active-high
//  result_valid_i  in   1        lane result present this cycle
//  result_addr_i   in   5        destination vreg index
//  result_bweb_i   in   VLEN/8   byte write enable, 1 = write byte
//  result_data_i   in   VLEN     result data, byte-aligned to bweb
//  stall_o         out  1        hold-off to sequencer (almost full)
//  vrf_we_o        out  1        VRF write request (valid)
//  vrf_ready_i     in   1        VRF accepts write this cycle
//  vrf_waddr_o     out  5        VRF write address
//  vrf_bweb_o      out  VLEN/8   VRF byte enables, 1 = write
//  vrf_wdata_o     out  VLEN     VRF write data
//  pending_o       out  32       bit r set = write to vreg r still buffered
//  empty_o         out  1        no buffered entries
//  overflow_o      out  1        sticky: push dropped while full
// BEHAVIOUR
//  - Reset (async, rst_i=1): count=0, rd/wr ptr=0, overflow_o=0; hence
//    vrf_we_o=0, vrf_waddr_o=0, vrf_bweb_o=0, vrf_wdata_o=0, pending_o=0,
//    empty_o=1, stall_o=0. Reset mid-drain discards all entries.
//  - Push: result_valid_i && |result_bweb_i. A valid with bweb==0 is ignored.
//  - Pop: vrf_we_o && vrf_ready_i. vrf_* driven from head entry flops;
//    vrf_we_o = (count!=0). Head is held stable while vrf_ready_i=0.
//  - Latency: entry pushed at edge N is visible on vrf_* after edge N
//    (first cycle of N+1) if buffer was empty.
//  - Full (count==DEPTH): push with simultaneous pop is accepted (count
//    unchanged); push without pop is dropped and sets overflow_o (sticky
//    until reset).
//  - Empty: push+pop same cycle impossible (vrf_we_o=0); count becomes 1.
//  - Pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.
//  - stall_o = (count >= DEPTH-1), combinational from count flops; one
//    slot of slack covers the sequencer's one-cycle response.
//  - pending_o = OR over valid entries of (1 << addr); updates same cycle
//    as count.
//  - Stored bytes with bweb=0 are don't-care but must drive vrf_wdata_o
//    as 0 for those bytes (VRF ignores them; keeps waveforms clean).
// CONFIGURATION
//  VPU_WB_COALESCE_EN defined: a push whose addr equals the tail entry's
//   addr merges into the tail instead of allocating: tail.bweb |= bweb,
//   bytes with bweb=1 overwritten. No merge when tail is the head and a
//   pop occurs this cycle (allocate new entry instead). Merge never sets
//   overflow_o, even when full.
//  VPU_WB_COALESCE_EN undefined: every push allocates one entry.
// TESTING
//  1. Reset, push addr=3 bweb=0x01 data=0xAA, ready=1 -> next cycle
//     we=1 waddr=3 bweb=0x01 wdata[7:0]=0xAA, pending_o=0x8; then empty_o=1.
//  2. ready=0, push 4 distinct addrs 1,2,5,7 -> stall_o=1 after 3rd push,
//     count=4; 5th push addr=9 -> dropped, overflow_o=1, pending_o=0xA6.
//  3. Full, push addr=9 with ready=1 same cycle -> accepted, count stays 4,
//     drain order 2,5,7,9 (addr 1 popped), overflow_o stays 0.
//  4. COALESCE_EN, ready=0: push addr=4 bweb=0x0F data=0x11223344, then
//     addr=4 bweb=0xF0 data=0x55667788_00000000 -> count=1, head
//     bweb=0xFF wdata=0x55667788_11223344. Undefined: count=2.
//  5. valid=1 bweb=0x00 -> no push, count unchanged, pending_o unchanged.
//  6. 3 entries buffered, assert rst_i async mid-cycle -> vrf_we_o=0,
//     pending_o=0, empty_o=1 immediately; new push after release works.

Source files
------------

// File: rtl/vpu_wb_merge_buffer.sv
// vpu_wb_merge_buffer: byte-enabled VPU writeback FIFO draining to the VRF write port
//  Optional macro VPU_WB_COALESCE_EN: a push to the tail entry's vreg merges into it.
//  Ports:
//   clk_i, rst_i (async, active-high)
//   result_valid_i/addr_i/bweb_i/data_i : writeback stream in; bweb==0 is not a push
//   stall_o     : almost full (count >= DEPTH-1)
//   vrf_we_o/waddr_o/bweb_o/wdata_o, vrf_ready_i : head entry out, ready/valid
//   pending_o   : bitmap of vregs with a buffered write
//   empty_o     : no buffered entries
//   overflow_o  : sticky, a push was dropped while full
module vpu_wb_merge_buffer #(
  parameter int VLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              result_valid_i,
  input  logic [4:0]        result_addr_i,
  input  logic [VLEN/8-1:0] result_bweb_i,
  input  logic [VLEN-1:0]   result_data_i,
  output logic              stall_o,
  output logic              vrf_we_o,
  input  logic              vrf_ready_i,
  output logic [4:0]        vrf_waddr_o,
  output logic [VLEN/8-1:0] vrf_bweb_o,
  output logic [VLEN-1:0]   vrf_wdata_o,
  output logic [31:0]       pending_o,
  output logic              empty_o,
  output logic              overflow_o
);
  localparam int BW = VLEN / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [4:0]      r_addr [DEPTH];
  logic [BW-1:0]   r_bweb [DEPTH];
  logic [VLEN-1:0] r_data [DEPTH];
  logic [AW-1:0]   r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic            r_ovf;
  logic [AW-1:0]   w_tail, w_off;
  logic [VLEN-1:0] w_mask;
  logic [31:0]     w_pend;
  logic            w_push_req, w_pop, w_full, w_merge, w_alloc, w_drop;
  assign w_push_req = result_valid_i && |result_bweb_i;
  assign w_pop      = vrf_we_o && vrf_ready_i;
  assign w_full     = r_count == CW'(DEPTH);
  assign w_tail     = r_wr_ptr - AW'(1);
`ifdef VPU_WB_COALESCE_EN
  // A lone entry that is leaving this cycle cannot absorb the push.
  assign w_merge = w_push_req && (r_count != '0) && (r_addr[w_tail] == result_addr_i) &&
                   !((r_count == CW'(1)) && w_pop);
`else
  assign w_merge = 1'b0;
`endif
  assign w_alloc = w_push_req && !w_merge && (!w_full || w_pop);
  assign w_drop  = w_push_req && !w_merge && w_full && !w_pop;
  always_comb begin
    w_mask = '0;
    w_pend = '0;
    w_off  = '0;
    for (int b = 0; b < BW; b++) w_mask[8*b +: 8] = {8{result_bweb_i[b]}};
    for (int i = 0; i < DEPTH; i++) begin
      w_off = AW'(i) - r_rd_ptr;
      if ({1'b0, w_off} < r_count) w_pend = w_pend | (32'd1 << r_addr[i]);
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_alloc) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_count <= r_count + CW'(w_alloc) - CW'(w_pop);
      r_ovf   <= r_ovf | w_drop;
    end
  end
  // Data is stored pre-masked so disabled bytes always read back as zero.
  always_ff @(posedge clk_i) begin
    if (w_alloc) begin
      r_addr[r_wr_ptr] <= result_addr_i;
      r_bweb[r_wr_ptr] <= result_bweb_i;
      r_data[r_wr_ptr] <= result_data_i & w_mask;
    end else if (w_merge) begin
      r_bweb[w_tail] <= r_bweb[w_tail] | result_bweb_i;
      r_data[w_tail] <= (r_data[w_tail] & ~w_mask) | (result_data_i & w_mask);
    end
  end
  assign vrf_we_o    = r_count != '0;
  assign vrf_waddr_o = vrf_we_o ? r_addr[r_rd_ptr] : '0;
  assign vrf_bweb_o  = vrf_we_o ? r_bweb[r_rd_ptr] : '0;
  assign vrf_wdata_o = vrf_we_o ? r_data[r_rd_ptr] : '0;
  assign pending_o   = w_pend;
  assign empty_o     = !vrf_we_o;
  assign stall_o     = r_count >= CW'(DEPTH - 1);
  assign overflow_o  = r_ovf;
endmodule

// File: tb/tb_vpu_wb_merge_buffer.sv
// tb_vpu_wb_merge_buffer: directed + randomized check of vpu_wb_merge_buffer against a queue model
module tb_vpu_wb_merge_buffer;
  localparam int VLEN  = 64;
  localparam int DEPTH = 4;
  typedef struct {
    logic [4:0]  a;
    logic [7:0]  be;
    logic [63:0] d;
  } ent_t;
  logic        clk = 1'b0;
  logic        rst;
  logic        valid, ready;
  logic [4:0]  addr;
  logic [7:0]  bweb;
  logic [63:0] data;
  logic        stall, we, empty, ovf;
  logic [4:0]  waddr;
  logic [7:0]  wbweb;
  logic [63:0] wdata;
  logic [31:0] pending;
  ent_t        q[$];
  logic        m_ovf;
  int          n_tests = 0;
  int          n_fail  = 0;
  vpu_wb_merge_buffer #(.VLEN(VLEN), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .result_valid_i(valid), .result_addr_i(addr), .result_bweb_i(bweb), .result_data_i(data),
    .stall_o(stall), .vrf_we_o(we), .vrf_ready_i(ready), .vrf_waddr_o(waddr),
    .vrf_bweb_o(wbweb), .vrf_wdata_o(wdata), .pending_o(pending),
    .empty_o(empty), .overflow_o(ovf)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [63:0] expand(input logic [7:0] be);
    logic [63:0] m = '0;
    for (int b = 0; b < 8; b++) if (be[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction
  task automatic compare_all();
    logic [31:0] p = '0;
    bit          ne = q.size() != 0;
    foreach (q[i]) p |= 32'd1 << q[i].a;
    check("we", we, ne);
    check("waddr", waddr, ne ? q[0].a : 5'd0);
    check("bweb", wbweb, ne ? q[0].be : 8'd0);
    check("wdata", wdata, ne ? q[0].d : 64'd0);
    check("pending", pending, p);
    check("empty", empty, !ne);
    check("stall", stall, q.size() >= DEPTH - 1);
    check("overflow", ovf, m_ovf);
  endtask
  task automatic cycle(input logic v, input logic [4:0] a, input logic [7:0] be,
                       input logic [63:0] d, input logic rdy);
    int          sz;
    bit          push, pop, mrg;
    logic [63:0] m;
    valid = v; addr = a; bweb = be; data = d; ready = rdy;
    #1 compare_all();
    @(posedge clk);
    sz   = q.size();
    m    = expand(be);
    push = v && (be != 0);
    pop  = (sz != 0) && rdy;
    mrg  = 0;
`ifdef VPU_WB_COALESCE_EN
    mrg = push && (sz != 0) && (q[sz-1].a == a) && !(sz == 1 && pop);
`endif
    if (pop) void'(q.pop_front());
    if (mrg) begin
      q[q.size()-1].be = q[q.size()-1].be | be;
      q[q.size()-1].d  = (q[q.size()-1].d & ~m) | (d & m);
    end else if (push) begin
      if (sz < DEPTH || pop) q.push_back('{a, be, d & m});
      else m_ovf = 1'b1;
    end
    #1;
  endtask
  task automatic do_reset();
    valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_we", we, 1'b0);
    check("rst_pending", pending, 32'd0);
    check("rst_empty", empty, 1'b1);
    q.delete();
    m_ovf = 1'b0;
    compare_all();
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; valid = 1'b0; ready = 1'b0; addr = '0; bweb = '0; data = '0;
    m_ovf = 1'b0;
    #12 compare_all();
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    cycle(1, 5'd3, 8'h01, 64'hAA, 1);
    check("t1_waddr", waddr, 5'd3);
    check("t1_wdata", wdata, 64'hAA);
    check("t1_pending", pending, 32'h8);
    cycle(0, 5'd0, 8'h00, 64'd0, 1);
    cycle(0, 5'd0, 8'h00, 64'd0, 1);
    cycle(1, 5'd1, 8'h03, 64'h1111, 0);
    cycle(1, 5'd2, 8'h0C, 64'h2222_0000, 0);
    cycle(1, 5'd5, 8'h30, 64'h3333_0000_0000, 0);
    cycle(1, 5'd7, 8'hC0, 64'h4444_0000_0000_0000, 0);
    cycle(1, 5'd9, 8'hFF, 64'hDEAD_BEEF, 0);
    check("t2_pending", pending, 32'hA6);
    check("t2_overflow", ovf, 1'b1);
    do_reset();
    cycle(1, 5'd1, 8'h01, 64'h01, 0);
    cycle(1, 5'd2, 8'h01, 64'h02, 0);
    cycle(1, 5'd5, 8'h01, 64'h05, 0);
    cycle(1, 5'd7, 8'h01, 64'h07, 0);
    cycle(1, 5'd9, 8'h01, 64'h09, 1);
    check("t3_pending", pending, 32'h2A4);
    check("t3_overflow", ovf, 1'b0);
    for (int i = 0; i < 5; i++) cycle(0, 5'd0, 8'h00, 64'd0, 1);
    do_reset();
    cycle(1, 5'd4, 8'h0F, 64'h11223344, 0);
    cycle(1, 5'd4, 8'hF0, 64'h55667788_00000000, 0);
`ifdef VPU_WB_COALESCE_EN
    check("t4_bweb", wbweb, 8'hFF);
    check("t4_wdata", wdata, 64'h55667788_11223344);
`else
    check("t4_bweb", wbweb, 8'h0F);
    check("t4_wdata", wdata, 64'h11223344);
`endif
    cycle(1, 5'd6, 8'h00, 64'hFFFF, 0);
    cycle(0, 5'd0, 8'h00, 64'd0, 0);
    cycle(1, 5'd10, 8'h01, 64'h1, 0);
    do_reset();
    cycle(1, 5'd12, 8'h81, 64'hFF00_0000_0000_00FF, 1);
    cycle(0, 5'd0, 8'h00, 64'd0, 1);
    for (int i = 0; i < 800; i++) begin
      logic [4:0] ra;
      logic [7:0] rb;
      ra = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
      rb = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 99) == 0) do_reset();
      else cycle($urandom_range(0, 9) < 7, ra, rb, {$urandom, $urandom}, $urandom_range(0, 1) == 1);
    end
    valid = 1'b0;
    #1 compare_all();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
